fetch_sequencer: RTL and testbench

- Program-counter sequencer for the core front end.
- Owns the PC register and issues one instruction-fetch request at a time to instruction memory over a valid/ready request channel and a valid-only response channel.
- Presents each fetched instruction to decode over a valid/ready handshake.
- Advances the PC by +4 per retired fetch, or loads a redirect target from execute (branch/jump/trap).

---
 rtl/fetch_sequencer.sv | 155 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Front-end PC sequencer: one fetch in flight, presents each
// instruction to decode, handles redirects and misaligned targets.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        misaligned_fault
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN,
        S_FAULT
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] pc;
    logic [31:0] pc_n;
    logic        req_n;
    logic        iv_n;
    logic [31:0] ipc_n;
    logic [31:0] idata_n;
    logic        fault_n;
    logic        pend;
    logic        pend_n;

    logic        accept;
    logic        busy;
    logic        aligned;

    assign imem_req_addr = pc;

    // Request accepted this edge, and whether a response is still owed
    always_comb begin
        accept  = imem_req_valid && imem_req_ready;
        aligned = (redirect_pc[1:0] == 2'b00);
        busy    = accept
                || (((state == S_WAIT) || (state == S_DRAIN))
                    && !imem_rsp_valid);
    end

    // Next-state and next-output decode
    always_comb begin
        state_n = state;
        pc_n    = pc;
        req_n   = imem_req_valid;
        iv_n    = inst_valid;
        ipc_n   = inst_pc;
        idata_n = inst_data;
        fault_n = 1'b0;
        pend_n  = pend;

        if (redirect_valid) begin
            iv_n = 1'b0;
            if (aligned) begin
                pc_n    = redirect_pc;
                pend_n  = 1'b0;
                state_n = busy ? S_DRAIN : S_REQ;
            end else begin
                fault_n = 1'b1;
                pend_n  = busy;
                state_n = busy ? S_DRAIN : S_FAULT;
            end
            req_n = (state_n == S_REQ) ? !stall : 1'b0;
        end else begin
            unique case (state)
                S_REQ: begin
                    if (accept) begin
                        req_n   = 1'b0;
                        state_n = S_WAIT;
                    end else if (imem_req_valid) begin
                        req_n = 1'b1;
                    end else begin
                        req_n = !stall;
                    end
                end
                S_WAIT: begin
                    req_n = 1'b0;
                    if (imem_rsp_valid) begin
                        idata_n = imem_rsp_data;
                        ipc_n   = pc;
                        iv_n    = 1'b1;
                        pc_n    = pc + 32'd4;
                        state_n = S_HOLD;
                    end
                end
                S_HOLD: begin
                    req_n = 1'b0;
                    if (inst_ready) begin
                        iv_n    = 1'b0;
                        req_n   = !stall;
                        state_n = S_REQ;
                    end
                end
                S_DRAIN: begin
                    req_n = 1'b0;
                    if (imem_rsp_valid) begin
                        pend_n  = 1'b0;
                        state_n = pend ? S_FAULT : S_REQ;
                        req_n   = pend ? 1'b0 : !stall;
                    end
                end
                S_FAULT: begin
                    req_n = 1'b0;
                    iv_n  = 1'b0;
                end
                default: begin
                    req_n   = 1'b0;
                    iv_n    = 1'b0;
                    state_n = S_REQ;
                end
            endcase
        end
    end

    // State and output registers; reset keeps track of an owed response
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= busy ? S_DRAIN : S_REQ;
            pc               <= RESET_PC;
            imem_req_valid   <= 1'b0;
            inst_valid       <= 1'b0;
            inst_pc          <= 32'd0;
            inst_data        <= 32'd0;
            misaligned_fault <= 1'b0;
            pend             <= 1'b0;
        end else begin
            state            <= state_n;
            pc               <= pc_n;
            imem_req_valid   <= req_n;
            inst_valid       <= iv_n;
            inst_pc          <= ipc_n;
            inst_data        <= idata_n;
            misaligned_fault <= fault_n;
            pend             <= pend_n;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, back-pressure,
// redirects, misaligned fault, PC wrap and reset during a fetch.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        misaligned_fault;

    int tests = 0;
    int fails = 0;

    fetch_sequencer #(.RESET_PC(32'h0000_0100)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .imem_req_valid   (imem_req_valid),
        .imem_req_addr    (imem_req_addr),
        .imem_req_ready   (imem_req_ready),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .inst_valid       (inst_valid),
        .inst_pc          (inst_pc),
        .inst_data        (inst_data),
        .inst_ready       (inst_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .stall            (stall),
        .misaligned_fault (misaligned_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a request, accept it, answer after lat cycles
    task automatic fetch_one(input logic [31:0] exp_pc, input int lat,
                             input logic [31:0] data);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req_valid === 1'b1) begin
                seen = 1;
                break;
            end
            tick();
        end
        chk("req_seen", {31'd0, seen}, 32'd1);
        chk("req_addr", imem_req_addr, exp_pc);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("req_drop", {31'd0, imem_req_valid}, 32'd0);
        repeat (lat - 1) tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        tick();
        imem_rsp_valid = 1'b0;
        chk("inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("inst_pc", inst_pc, exp_pc);
        chk("inst_data", inst_data, data);
    endtask

    initial begin
        reset_n        = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        stall          = 1'b0;
        tick();
        tick();
        chk("rst_addr", imem_req_addr, 32'h100);
        chk("rst_req", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_iv", {31'd0, inst_valid}, 32'd0);
        chk("rst_ipc", inst_pc, 32'd0);
        chk("rst_idata", inst_data, 32'd0);
        chk("rst_fault", {31'd0, misaligned_fault}, 32'd0);
        reset_n = 1'b1;

        // sequential fetch, latency 2
        fetch_one(32'h100, 2, 32'h13);
        tick();
        fetch_one(32'h104, 2, 32'h13);
        tick();
        fetch_one(32'h108, 2, 32'h13);
        tick();
        chk("seq_consumed", {31'd0, inst_valid}, 32'd0);

        // back-pressure with stall toggling
        for (int i = 0; i < 5; i++) begin
            stall = i[0];
            tick();
            chk("bp_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("bp_addr", imem_req_addr, 32'h10C);
        end
        stall = 1'b0;
        fetch_one(32'h10C, 1, 32'h5);
        tick();

        // redirect coincident with the response
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        chk("rc_iv", {31'd0, inst_valid}, 32'd0);
        chk("rc_addr", imem_req_addr, 32'h200);
        chk("rc_req", {31'd0, imem_req_valid}, 32'd1);
        fetch_one(32'h200, 1, 32'hAA);
        tick();

        // redirect in WAIT, orphan response drained
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        chk("dr_req", {31'd0, imem_req_valid}, 32'd0);
        chk("dr_addr", imem_req_addr, 32'h300);
        tick();
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD;
        tick();
        imem_rsp_valid = 1'b0;
        chk("dr_iv", {31'd0, inst_valid}, 32'd0);
        chk("dr_req2", {31'd0, imem_req_valid}, 32'd1);
        inst_ready = 1'b0;
        fetch_one(32'h300, 1, 32'h33);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_iv", {31'd0, inst_valid}, 32'd1);
            chk("hold_pc", inst_pc, 32'h300);
            chk("hold_data", inst_data, 32'h33);
            chk("hold_req", {31'd0, imem_req_valid}, 32'd0);
        end
        inst_ready = 1'b1;
        tick();
        chk("hold_done", {31'd0, inst_valid}, 32'd0);

        // misaligned redirect, then recovery
        redirect_valid = 1'b1;
        redirect_pc    = 32'h302;
        tick();
        redirect_valid = 1'b0;
        chk("mf_pulse", {31'd0, misaligned_fault}, 32'd1);
        chk("mf_addr", imem_req_addr, 32'h304);
        chk("mf_req", {31'd0, imem_req_valid}, 32'd0);
        tick();
        chk("mf_pulse_end", {31'd0, misaligned_fault}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mf_idle", {31'd0, imem_req_valid}, 32'd0);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        tick();
        redirect_valid = 1'b0;
        chk("mf_resume", {31'd0, imem_req_valid}, 32'd1);
        fetch_one(32'h400, 2, 32'h44);
        tick();

        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        fetch_one(32'hFFFF_FFFC, 1, 32'h77);
        tick();
        fetch_one(32'h0, 1, 32'h88);
        tick();

        // reset during WAIT, late response ignored
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rw_addr", imem_req_addr, 32'h100);
        chk("rw_req", {31'd0, imem_req_valid}, 32'd0);
        chk("rw_iv", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("rw_drain", {31'd0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hFEED;
        tick();
        imem_rsp_valid = 1'b0;
        chk("rw_iv2", {31'd0, inst_valid}, 32'd0);
        fetch_one(32'h100, 1, 32'h99);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
